step_pattern_sequencer: RTL
===========================

# step_pattern_sequencer

Stores a 16-step tone pattern and plays it back one step per tempo pulse. It sits directly upstream of the tone generators: it consumes the single-cycle `step` pulse from the BPM counter and drives the 12-bit tone-select bus and the play enable into the audio generators and the codec/DAC path. Pattern edits from switches/keys can be written at any time, including during playback.

## Interface
- `STEPS`, 16: pattern length; power of two.
- `TONES`, 12: tone-select width; one bit per semitone.
- `GAP_CYCLES`, 250000: articulation gap length in clocks (5 ms at 50 MHz); used only with `STEP_SEQ_GATE_EN`.

- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse; (re)start playback at step 0.
- `stop`  in  1  one-cycle pulse; abort playback.
- `step`  in  1  one-cycle tempo pulse from the BPM counter.
- `loops`  in  3  pattern passes; 0 = loop forever; sampled on `start`.
- `wr_en`  in  1  pattern write strobe.
- `wr_addr`  in  4  step index to write.
- `wr_data`  in  12  tone mask for that step.
- `rd_addr`  in  4  display read index.
- `rd_data`  out  12  registered pattern[`rd_addr`].
- `select`  out  12  registered tone mask of the current step; 0 when idle.
- `play`  out  1  high while in PLAY.
- `cur_step`  out  4  current step index.
- `loop_done`  out  1  one-cycle pulse when the final pass completes.

## Operation
- Reset values: all outputs 0, all pattern entries 0, loop counter 0, state IDLE.
- States: IDLE and PLAY.
- IDLE -> PLAY on `start`. `loops` is latched, `cur_step` = 0, and the loop counter is cleared.
- PLAY -> IDLE on `stop`, or when the final pass completes.
- `start` in PLAY restarts at step 0 and re-latches `loops`.
- In PLAY, `step` advances `cur_step`. At `STEPS-1` it wraps to 0 and increments the loop counter.
- If latched `loops` != 0 and the wrap completes pass number `loops`, the block goes to IDLE, pulses `loop_done`, and sets `cur_step` = 0.
- Loop counter is 3 bits. With `loops` = 0 it wraps freely and never terminates playback.
- Precedence in a single cycle: `stop` > `start` > `step`.
  - `start` together with `step`: restart at step 0; the step is ignored.
  - `step` in IDLE is ignored.
- Writes:
  - `wr_en` writes the pattern in any state.
  - A write to the step currently playing changes `select` two cycles later, without waiting for the next step.
  - A write and a read of the same address in the same cycle returns the old data on `rd_data`; the new data appears the following cycle.
- `select` is refreshed every cycle from pattern[`cur_step`] while `play`; it is 0 otherwise.

## Timing
- `start` at cycle t: `play` = 1 and `cur_step` = 0 at t+1; `select` = pattern[0] at t+2.
- `step` at t: `cur_step` updates at t+1; `select` updates at t+2.
- `stop` at t: `play` = 0 at t+1; `select` = 0 at t+2.
- Final wrap at t: `play` = 0 and `loop_done` = 1 at t+1, with `loop_done` lasting exactly one cycle; `select` = 0 at t+2.
- `rd_data`: one-cycle read latency.
- Reset mid-playback: the next cycle shows all reset values, and the pattern is cleared.

## Configuration
- `STEP_SEQ_GATE_EN` defined:
  - A down-counter loads `GAP_CYCLES` on every step entry (start, restart, each advance).
  - `select` is forced to 0 while the counter is nonzero, giving re-articulation of repeated notes.
  - `play` is unaffected.
- `STEP_SEQ_GATE_EN` undefined: no gap counter; `select` follows the pattern continuously and repeated notes are held legato.

## Structure
- Shared package `seq_pkg` holds:
  - `STEPS`, `TONES`, and `GAP_CYCLES` defaults.
  - `step_t` (4-bit index) and `tone_t` (12-bit mask).
  - State enum `seq_state_t` {IDLE, PLAY}.
- Sub-module `pattern_ram`: STEPS x TONES flop array, synchronously cleared by `reset`, with one write port and two registered read ports (playback, display).
- The top contains the FSM, step/loop counters, and the optional gap counter.

## Test plan
- Reset, write pattern[i] = 1<<(i%12) for all i, `loops` = 2, pulse `start` then 32 `step`s -> `select` walks 0x001, 0x002, ..., 0x800, 0x001..., two full passes. `loop_done` pulses once after step 32; then `play` = 0 and `select` = 0.
- `loops` = 0, 40 `step`s -> playback continues and `cur_step` = 40 mod 16 = 8; `stop` -> `play` = 0 next cycle.
- `start` and `step` in the same cycle during PLAY at `cur_step` = 5 -> `cur_step` = 0, no advance to 6; `stop` and `start` together -> IDLE.
- While at step 3, write pattern[3] = 0xABC -> `select` = 0xABC two cycles later; `rd_addr` = 3 -> `rd_data` = 0xABC.
- `reset` asserted mid-pass -> all outputs 0 next cycle; `rd_data` = 0 for every address.
- With `STEP_SEQ_GATE_EN` and `GAP_CYCLES` = 4 -> `select` = 0 for 4 cycles after each step entry, then shows the pattern value; `play` stays 1.

Source files
------------

// File: rtl/step_pattern_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and defaults for the step pattern sequencer.
//   STEPS       pattern length (power of two)
//   TONES       tone-select width, one bit per semitone
//   GAP_CYCLES  articulation gap length in clocks (used with STEP_SEQ_GATE_EN)
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam int STEPS      = 16;
  localparam int TONES      = 12;
  localparam int GAP_CYCLES = 250000;
  localparam int LOOP_W     = 3;

  typedef logic [$clog2(STEPS)-1:0]        step_t;
  typedef logic [TONES-1:0]                tone_t;
  typedef logic [LOOP_W-1:0]               loop_t;
  typedef logic [$clog2(GAP_CYCLES+1)-1:0] gap_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  localparam step_t LAST_STEP = step_t'(STEPS - 1);

endpackage

// File: rtl/step_pattern_sequencer_if.sv
// -----------------------------------------------------------------------------
// step_pattern_sequencer_if
// Control, pattern-edit and playback signals of the step pattern sequencer.
//   start/stop/step  one-cycle control pulses
//   loops            pattern passes, 0 = forever (sampled on start)
//   wr_en/wr_addr/wr_data  pattern write port
//   rd_addr/rd_data  display read port (one-cycle latency)
//   select/play/cur_step/loop_done  playback outputs
// master: the controlling side (drives pulses/edits); slave: the sequencer.
// -----------------------------------------------------------------------------
interface step_pattern_sequencer_if
  import seq_pkg::*;
();

  logic  start;
  logic  stop;
  logic  step;
  loop_t loops;
  logic  wr_en;
  step_t wr_addr;
  tone_t wr_data;
  step_t rd_addr;
  tone_t rd_data;
  tone_t select;
  logic  play;
  step_t cur_step;
  logic  loop_done;

  modport master (
    output start, stop, step, loops, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, select, play, cur_step, loop_done
  );

  modport slave (
    input  start, stop, step, loops, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, select, play, cur_step, loop_done
  );

endinterface

// File: rtl/step_pattern_sequencer_pattern_ram.sv
// -----------------------------------------------------------------------------
// pattern_ram
// STEPS x TONES flop array holding the tone pattern.
//   clk        clock
//   reset      synchronous active-high clear of array and read registers
//   wr_en/wr_addr/wr_data  single write port
//   play_addr -> play_data  registered playback read port
//   rd_addr   -> rd_data    registered display read port
// A read of the address being written returns the old data (read-before-write).
// -----------------------------------------------------------------------------
module pattern_ram
  import seq_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  step_t wr_addr,
  input  tone_t wr_data,
  input  step_t play_addr,
  output tone_t play_data,
  input  step_t rd_addr,
  output tone_t rd_data
);

  tone_t mem [STEPS];

  // NOTE: the array is a flop bank, not a RAM macro, so it can and must be
  // cleared on reset; the pattern is expected to read back as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
      play_data <= '0;
      rd_data   <= '0;
    end else begin
      // NOTE: non-blocking updates make both reads see the pre-write contents,
      // which gives read-before-write on an address collision for free.
      if (wr_en) mem[wr_addr] <= wr_data;
      play_data <= mem[play_addr];
      rd_data   <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/step_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// step_pattern_sequencer
// Plays a 16-step tone pattern, one step per tempo pulse, for a set number of
// passes or forever.
//   CLOCK_50  system clock
//   reset     synchronous active-high reset
//   bus       step_pattern_sequencer_if.slave (controls, edits, outputs)
// Optional feature macro STEP_SEQ_GATE_EN: after every step entry, select is
// held at 0 for GAP_CYCLES clocks to re-articulate repeated notes.
// -----------------------------------------------------------------------------
module step_pattern_sequencer
  import seq_pkg::*;
`ifdef STEP_SEQ_GATE_EN
#(
  parameter int GAP_CYCLES = seq_pkg::GAP_CYCLES
)
`endif
(
  input logic                      CLOCK_50,
  input logic                      reset,
  step_pattern_sequencer_if.slave  bus
);

  seq_state_t state, state_next;
  step_t      cur_step, step_next;
  loop_t      loop_cnt, loop_next;
  loop_t      loops_q, loops_next;
  logic       done_q, done_next;
  logic       sel_en;
  logic       gap_open;
  tone_t      play_data;

  // Next-state logic. Priority inside PLAY is stop > start > step.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    state_next = state;
    step_next  = cur_step;
    loop_next  = loop_cnt;
    loops_next = loops_q;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_next = PLAY;
          step_next  = '0;
          loop_next  = '0;
          loops_next = bus.loops;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_next = IDLE;
          step_next  = '0;
        end else if (bus.start) begin
          step_next  = '0;
          loop_next  = '0;
          loops_next = bus.loops;
        end else if (bus.step) begin
          if (cur_step == LAST_STEP) begin
            step_next = '0;
            loop_next = loop_cnt + 1'b1;
            // loops == 0 never matches, so the counter just wraps freely.
            if (loops_q != '0 && loop_next == loops_q) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            step_next = cur_step + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      cur_step <= '0;
      loop_cnt <= '0;
      loops_q  <= '0;
      done_q   <= 1'b0;
      sel_en   <= 1'b0;
    end else begin
      state    <= state_next;
      cur_step <= step_next;
      loop_cnt <= loop_next;
      loops_q  <= loops_next;
      done_q   <= done_next;
      // Aligned with the registered playback read, so select follows
      // play and the gap with the same two-cycle latency as the pattern.
      sel_en   <= (state == PLAY) && gap_open;
    end
  end

`ifdef STEP_SEQ_GATE_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  logic             entry;
  logic [GAP_W-1:0] gap_cnt;

  // A step entry is any cycle that leaves the FSM in PLAY on a new (or
  // restarted) step: start from IDLE, restart, or a non-final advance.
  assign entry = (state_next == PLAY) && (state == IDLE || bus.start || bus.step);

  always_ff @(posedge CLOCK_50) begin
    if (reset)               gap_cnt <= '0;
    else if (entry)          gap_cnt <= GAP_W'(GAP_CYCLES);
    else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
  end

  assign gap_open = (gap_cnt == '0);
`else
  assign gap_open = 1'b1;
`endif

  pattern_ram u_pattern_ram (
    .clk       (CLOCK_50),
    .reset     (reset),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .play_addr (cur_step),
    .play_data (play_data),
    .rd_addr   (bus.rd_addr),
    .rd_data   (bus.rd_data)
  );

  assign bus.play      = (state == PLAY);
  assign bus.cur_step  = cur_step;
  assign bus.loop_done = done_q;
  assign bus.select    = play_data & {TONES{sel_en}};

endmodule
